// File: rtl/branch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq_pkg
// Description : Branch opcode encoding, sequencer state encoding and operand
//               dependency helpers shared by the branch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_seq_pkg;

    localparam logic [2:0] c_OP_NONE   = 3'd0;
    localparam logic [2:0] c_OP_EQ     = 3'd1;
    localparam logic [2:0] c_OP_NE     = 3'd2;
    localparam logic [2:0] c_OP_GEZ    = 3'd3;
    localparam logic [2:0] c_OP_GTZ    = 3'd4;
    localparam logic [2:0] c_OP_LEZ    = 3'd5;
    localparam logic [2:0] c_OP_LTZ    = 3'd6;
    localparam logic [2:0] c_OP_ALWAYS = 3'd7;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_RESOLVE = 2'd2;
    localparam logic [1:0] c_ST_SLOT    = 2'd3;

    // Only the two-register compares consume Rd2.
    function automatic logic needs_rt(input logic [2:0] op);
        return (op == c_OP_EQ) || (op == c_OP_NE);
    endfunction

    // Unconditional jumps and NONE depend on no register at all.
    function automatic logic needs_rs(input logic [2:0] op);
        return (op != c_OP_NONE) && (op != c_OP_ALWAYS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_ctr.sv
`default_nettype none
// ============================================================================
// Module      : perf_ctr
// Description : Event counter that either wraps or saturates at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_ctr #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             w_hold;

    assign w_hold = SATURATE && (r_count == c_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !w_hold) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_seq.sv
`default_nettype none
// ============================================================================
// Module      : branch_seq
// Description : D-stage branch sequencer: operand wait, resolve, delay slot,
//               registered PC redirect and branch performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [31:0]      br_target,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             flush,
    input  logic             cmp_taken,
    output logic [2:0]       cmp_op,
    output logic             d_stall,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_slot_br
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_op;
    logic [31:0] r_target;
    logic        r_pc_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_err_slot_br;

    logic        w_capture;
    logic        w_resolve;
    logic        w_taken;
    logic        w_stall;
    logic [2:0]  w_cmp_op;
    logic        w_rst;

    function automatic logic ops_ready(input logic [2:0] op, input logic rs, input logic rt);
        return (!needs_rs(op) || rs) && (!needs_rt(op) || rt);
    endfunction

    // NONE never redirects, even if the external comparator claims taken.
    assign w_taken = (r_op == c_OP_ALWAYS) || ((r_op != c_OP_NONE) && cmp_taken);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_resolve   = 1'b0;
        w_stall     = 1'b0;
        w_cmp_op    = c_OP_NONE;
        case (r_state)
            c_ST_IDLE: begin
                w_stall = br_valid;
                if (br_valid && !flush) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ops_ready(br_op, rs_ready, rt_ready) ? c_ST_RESOLVE : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_stall = 1'b1;
                if (ops_ready(r_op, rs_ready, rt_ready)) begin
                    w_state_nxt = c_ST_RESOLVE;
                end
            end
            c_ST_RESOLVE: begin
                w_cmp_op    = r_op;
                w_resolve   = !flush;
                w_state_nxt = c_ST_SLOT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = c_ST_IDLE;
        end
        // Hold the pipeline interface quiet while reset is asserted.
        if (!reset) begin
            w_stall   = 1'b0;
            w_cmp_op  = c_OP_NONE;
            w_capture = 1'b0;
            w_resolve = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_op          <= c_OP_NONE;
            r_target      <= '0;
            r_pc_redirect <= 1'b0;
            r_redirect_pc <= '0;
            r_err_slot_br <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_redirect <= w_resolve && w_taken;
            if (w_capture) begin
                r_op     <= br_op;
                r_target <= br_target;
            end
            if (w_resolve) begin
                r_redirect_pc <= r_target;
            end
            if ((r_state == c_ST_SLOT) && br_valid) begin
                r_err_slot_br <= 1'b1;
            end
        end
    end

    assign w_rst = ~reset;

    perf_ctr #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_br_ctr (
        .clk     (clk),
        .rst     (w_rst),
        .i_inc   (w_resolve),
        .o_count (br_cnt)
    );

    perf_ctr #(.WIDTH(CNT_W), .SATURATE(1'b0)) u_taken_ctr (
        .clk     (clk),
        .rst     (w_rst),
        .i_inc   (w_resolve && w_taken),
        .o_count (taken_cnt)
    );

    perf_ctr #(.WIDTH(CNT_W), .SATURATE(1'b1)) u_stall_ctr (
        .clk     (clk),
        .rst     (w_rst),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );

    assign cmp_op      = w_cmp_op;
    assign d_stall     = w_stall;
    assign pc_redirect = r_pc_redirect;
    assign redirect_pc = r_redirect_pc;
    assign err_slot_br = r_err_slot_br;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_seq
// Description : Self-checking bench for branch_seq with redirect scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_seq;
    import branch_seq_pkg::*;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic             br_valid;
    logic [2:0]       br_op;
    logic [31:0]      br_target;
    logic             rs_ready;
    logic             rt_ready;
    logic             flush;
    logic             cmp_taken;
    logic [2:0]       cmp_op;
    logic             d_stall;
    logic             pc_redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_slot_br;

    always #5 clk = ~clk;

    branch_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .br_valid    (br_valid),
        .br_op       (br_op),
        .br_target   (br_target),
        .rs_ready    (rs_ready),
        .rt_ready    (rt_ready),
        .flush       (flush),
        .cmp_taken   (cmp_taken),
        .cmp_op      (cmp_op),
        .d_stall     (d_stall),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .br_cnt      (br_cnt),
        .taken_cnt   (taken_cnt),
        .stall_cnt   (stall_cnt),
        .err_slot_br (err_slot_br)
    );

    typedef struct {
        logic [2:0]  op;
        logic        rs;
        logic        rt;
        logic        cmp;
        logic [31:0] tgt;
        logic        exp_taken;
    } vec_t;

    vec_t             vecs[8];
    vec_t             v;
    logic [31:0]      sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_br;
    logic [CNT_W-1:0] exp_taken;
    logic [CNT_W-1:0] exp_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == c_MAX) ? x : x + c_ONE;
    endfunction

    // Advance one cycle; any redirect pulse is matched against the scoreboard.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (pc_redirect === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_redirect", {31'd0, pc_redirect}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("redirect_pc", redirect_pc, e);
            end
        end
    endtask

    task automatic check_ctrs(input string tag);
        chk({tag, "_br_cnt"}, {28'd0, br_cnt}, {28'd0, exp_br});
        chk({tag, "_taken_cnt"}, {28'd0, taken_cnt}, {28'd0, exp_taken});
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, exp_stall});
    endtask

    task automatic idle_inputs();
        br_valid  = 1'b0;
        br_op     = c_OP_NONE;
        br_target = '0;
        rs_ready  = 1'b0;
        rt_ready  = 1'b0;
        flush     = 1'b0;
        cmp_taken = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        exp_br    = '0;
        exp_taken = '0;
        exp_stall = '0;
        check_ctrs("reset");
    endtask

    // Branch whose operands are ready at capture: IDLE -> RESOLVE -> SLOT -> IDLE.
    task automatic run_branch(input vec_t bv);
        br_valid  = 1'b1;
        br_op     = bv.op;
        rs_ready  = bv.rs;
        rt_ready  = bv.rt;
        br_target = bv.tgt;
        #1;
        chk("capture_stall", {31'd0, d_stall}, 32'd1);
        exp_stall = sat_inc(exp_stall);
        step();
        br_valid  = 1'b0;
        cmp_taken = bv.cmp;
        #1;
        chk("resolve_cmp_op", {29'd0, cmp_op}, {29'd0, bv.op});
        chk("resolve_stall", {31'd0, d_stall}, 32'd0);
        if (bv.exp_taken) begin
            sb_q.push_back(bv.tgt);
            exp_taken = exp_taken + c_ONE;
        end
        exp_br = exp_br + c_ONE;
        step();
        cmp_taken = 1'b0;
        rs_ready  = 1'b0;
        rt_ready  = 1'b0;
        #1;
        chk("slot_redirect", {31'd0, pc_redirect}, {31'd0, bv.exp_taken});
        chk("slot_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        check_ctrs("slot");
        step();
    endtask

    initial begin
        vecs[0] = '{c_OP_EQ,     1'b1, 1'b1, 1'b1, 32'h00400100, 1'b1};
        vecs[1] = '{c_OP_NE,     1'b1, 1'b1, 1'b0, 32'h00400200, 1'b0};
        vecs[2] = '{c_OP_GEZ,    1'b1, 1'b0, 1'b0, 32'h00400300, 1'b0};
        vecs[3] = '{c_OP_GTZ,    1'b1, 1'b0, 1'b1, 32'h00400400, 1'b1};
        vecs[4] = '{c_OP_LEZ,    1'b1, 1'b1, 1'b0, 32'h00400500, 1'b0};
        vecs[5] = '{c_OP_LTZ,    1'b1, 1'b1, 1'b1, 32'h00400600, 1'b1};
        vecs[6] = '{c_OP_ALWAYS, 1'b0, 1'b0, 1'b0, 32'h00400700, 1'b1};
        vecs[7] = '{c_OP_NONE,   1'b0, 1'b0, 1'b1, 32'h00400800, 1'b0};

        // Reset held low with a branch present: outputs quiet, state cleared.
        idle_inputs();
        reset    = 1'b0;
        br_valid = 1'b1;
        br_op    = c_OP_ALWAYS;
        rs_ready = 1'b1;
        rt_ready = 1'b1;
        step();
        step();
        chk("rst_d_stall", {31'd0, d_stall}, 32'd0);
        chk("rst_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        chk("rst_pc_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_err", {31'd0, err_slot_br}, 32'd0);
        exp_br    = '0;
        exp_taken = '0;
        exp_stall = '0;
        check_ctrs("rst");
        idle_inputs();
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_branch(vecs[i]);
        end

        // NE waiting on Rd2 for three cycles.
        apply_reset();
        br_valid  = 1'b1;
        br_op     = c_OP_NE;
        rs_ready  = 1'b1;
        rt_ready  = 1'b0;
        br_target = 32'h00400900;
        #1;
        chk("bne_cap_stall", {31'd0, d_stall}, 32'd1);
        step();
        br_valid = 1'b0;
        #1;
        chk("bne_wait1_stall", {31'd0, d_stall}, 32'd1);
        chk("bne_wait1_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        step();
        chk("bne_wait2_stall", {31'd0, d_stall}, 32'd1);
        step();
        rt_ready = 1'b1;
        #1;
        chk("bne_wait3_stall", {31'd0, d_stall}, 32'd1);
        step();
        cmp_taken = 1'b1;
        #1;
        chk("bne_resolve_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NE});
        chk("bne_resolve_stall", {31'd0, d_stall}, 32'd0);
        sb_q.push_back(32'h00400900);
        exp_br    = exp_br + c_ONE;
        exp_taken = exp_taken + c_ONE;
        exp_stall = 4'd4;
        step();
        idle_inputs();
        #1;
        chk("bne_slot_redirect", {31'd0, pc_redirect}, 32'd1);
        check_ctrs("bne");
        step();

        // Flush while waiting for operands.
        br_valid  = 1'b1;
        br_op     = c_OP_EQ;
        rs_ready  = 1'b1;
        rt_ready  = 1'b0;
        br_target = 32'h00400a00;
        #1;
        step();
        br_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("fw_wait_stall", {31'd0, d_stall}, 32'd1);
        step();
        flush    = 1'b0;
        rt_ready = 1'b1;
        #1;
        chk("fw_idle_stall", {31'd0, d_stall}, 32'd0);
        chk("fw_idle_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        step();
        chk("fw_no_resolve", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        idle_inputs();
        exp_stall = exp_stall + 4'd2;
        check_ctrs("fw");

        // Flush in RESOLVE with a taken jump.
        br_valid  = 1'b1;
        br_op     = c_OP_ALWAYS;
        br_target = 32'h00400b00;
        #1;
        step();
        br_valid  = 1'b0;
        flush     = 1'b1;
        cmp_taken = 1'b1;
        #1;
        chk("fr_resolve_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_ALWAYS});
        step();
        idle_inputs();
        #1;
        chk("fr_no_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("fr_idle_stall", {31'd0, d_stall}, 32'd0);
        exp_stall = sat_inc(exp_stall);
        check_ctrs("fr");
        step();

        // Flush beats a simultaneous branch in IDLE.
        br_valid  = 1'b1;
        br_op     = c_OP_ALWAYS;
        br_target = 32'h00400b80;
        flush     = 1'b1;
        #1;
        step();
        idle_inputs();
        #1;
        chk("fp_no_capture", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        step();
        chk("fp_br_cnt", {28'd0, br_cnt}, {28'd0, exp_br});

        // Branch seen in the delay slot.
        apply_reset();
        br_valid  = 1'b1;
        br_op     = c_OP_ALWAYS;
        br_target = 32'h00400c00;
        #1;
        exp_stall = sat_inc(exp_stall);
        step();
        br_valid = 1'b0;
        #1;
        sb_q.push_back(32'h00400c00);
        exp_br    = exp_br + c_ONE;
        exp_taken = exp_taken + c_ONE;
        step();
        br_valid = 1'b1;
        br_op    = c_OP_EQ;
        rs_ready = 1'b1;
        rt_ready = 1'b1;
        #1;
        chk("slotbr_stall", {31'd0, d_stall}, 32'd0);
        step();
        idle_inputs();
        #1;
        chk("slotbr_err", {31'd0, err_slot_br}, 32'd1);
        chk("slotbr_idle_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        chk("slotbr_idle_stall", {31'd0, d_stall}, 32'd0);
        repeat (3) step();
        chk("slotbr_err_sticky", {31'd0, err_slot_br}, 32'd1);
        check_ctrs("slotbr");

        // Reset arriving while the branch is in RESOLVE.
        br_valid  = 1'b1;
        br_op     = c_OP_ALWAYS;
        br_target = 32'h00400d00;
        #1;
        step();
        br_valid  = 1'b0;
        cmp_taken = 1'b1;
        reset     = 1'b0;
        #1;
        chk("midrst_cmp_op", {29'd0, cmp_op}, {29'd0, c_OP_NONE});
        step();
        reset     = 1'b1;
        cmp_taken = 1'b0;
        #1;
        chk("midrst_no_redirect", {31'd0, pc_redirect}, 32'd0);
        chk("midrst_err_clr", {31'd0, err_slot_br}, 32'd0);
        exp_br    = '0;
        exp_taken = '0;
        exp_stall = '0;
        check_ctrs("midrst");
        step();

        // Long stall saturates stall_cnt, then branches wrap br_cnt.
        br_valid  = 1'b1;
        br_op     = c_OP_EQ;
        rs_ready  = 1'b1;
        rt_ready  = 1'b0;
        br_target = 32'h00400e00;
        #1;
        step();
        br_valid = 1'b0;
        repeat (18) step();
        rt_ready = 1'b1;
        #1;
        step();
        cmp_taken = 1'b1;
        #1;
        sb_q.push_back(32'h00400e00);
        exp_br    = c_ONE;
        exp_taken = c_ONE;
        exp_stall = c_MAX;
        step();
        idle_inputs();
        #1;
        check_ctrs("sat");
        step();
        for (int i = 0; i < 15; i++) begin
            v.op        = c_OP_ALWAYS;
            v.rs        = 1'b0;
            v.rt        = 1'b0;
            v.cmp       = 1'b0;
            v.tgt       = 32'h00401000 + 32'(i * 4);
            v.exp_taken = 1'b1;
            run_branch(v);
        end
        chk("wrap_br_cnt", {28'd0, br_cnt}, 32'd0);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
